// File: rtl/key_mode_ctrl_if.sv
// Key/mode controller signal bundle: debounced key input, mode/transmit/LED
// status outputs, and read-only views of both FSM states.
interface key_mode_ctrl_if;
    logic       key_pulse_i;
    logic [3:0] mode_o;
    logic       tx_en_o;
    logic       mode_chg_o;
    logic       tx_chg_o;
    logic       led_o;
    logic       dbg_cls_state_o;
    logic [1:0] dbg_blk_state_o;

    modport master (
        output key_pulse_i,
        input  mode_o, tx_en_o, mode_chg_o, tx_chg_o, led_o,
        input  dbg_cls_state_o, dbg_blk_state_o
    );

    modport slave (
        input  key_pulse_i,
        output mode_o, tx_en_o, mode_chg_o, tx_chg_o, led_o,
        output dbg_cls_state_o, dbg_blk_state_o
    );
endinterface

// File: rtl/key_mode_ctrl.sv
// Classifies key presses into single (next mode) and double (toggle transmit)
// events, and blinks the status LED (new mode + 1) times after each event.
module key_mode_ctrl #(
    parameter int WIN_CYC   = 6000000,
    parameter int BLINK_CYC = 4000000,
    parameter int NUM_MODES = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    key_mode_ctrl_if.slave  bus
);
    // key_pulse_i is a one-cycle strobe with no back-pressure; every output is
    // a register and no handshake exists on either side.
    typedef enum logic       {CLS_IDLE, CLS_WAIT2}       cls_state_e;
    typedef enum logic [1:0] {BLK_OFF, BLK_ON, BLK_GAP} blk_state_e;

    localparam logic [23:0] WIN_LAST   = 24'(WIN_CYC - 1);
    localparam logic [23:0] BLINK_LAST = 24'(BLINK_CYC - 1);
    localparam logic [3:0]  MODE_LAST  = 4'(NUM_MODES - 1);

    cls_state_e cls_q, cls_d;
    blk_state_e blk_q, blk_d;
    logic [23:0] win_q, win_d;
    logic [23:0] phase_q, phase_d;
    logic [4:0]  blinks_q, blinks_d;
    logic [3:0]  mode_q, mode_d;
    logic        tx_en_q, tx_en_d;
    logic        mode_chg_q, mode_chg_d;
    logic        tx_chg_q, tx_chg_d;
    logic        led_q, led_d;
    logic        single_ev, double_ev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cls_q      <= CLS_IDLE;
            blk_q      <= BLK_OFF;
            win_q      <= '0;
            phase_q    <= '0;
            blinks_q   <= '0;
            mode_q     <= '0;
            tx_en_q    <= 1'b0;
            mode_chg_q <= 1'b0;
            tx_chg_q   <= 1'b0;
            led_q      <= 1'b0;
        end else begin
            cls_q      <= cls_d;
            blk_q      <= blk_d;
            win_q      <= win_d;
            phase_q    <= phase_d;
            blinks_q   <= blinks_d;
            mode_q     <= mode_d;
            tx_en_q    <= tx_en_d;
            mode_chg_q <= mode_chg_d;
            tx_chg_q   <= tx_chg_d;
            led_q      <= led_d;
        end
    end

    // A pulse on the last window cycle is checked first, so it wins as a double.
    always_comb begin
        cls_d     = cls_q;
        win_d     = win_q;
        single_ev = 1'b0;
        double_ev = 1'b0;
        case (cls_q)
            CLS_IDLE: begin
                if (bus.key_pulse_i) begin
                    cls_d = CLS_WAIT2;
                    win_d = '0;
                end
            end
            CLS_WAIT2: begin
                if (bus.key_pulse_i) begin
                    double_ev = 1'b1;
                    cls_d     = CLS_IDLE;
                    win_d     = '0;
                end else if (win_q == WIN_LAST) begin
                    single_ev = 1'b1;
                    cls_d     = CLS_IDLE;
                    win_d     = '0;
                end else begin
                    win_d = win_q + 24'd1;
                end
            end
            default: begin
                cls_d = CLS_IDLE;
                win_d = '0;
            end
        endcase
    end

    always_comb begin
        mode_d     = mode_q;
        tx_en_d    = tx_en_q;
        mode_chg_d = single_ev;
        tx_chg_d   = double_ev;
        if (single_ev) begin
            mode_d = (mode_q == MODE_LAST) ? 4'd0 : mode_q + 4'd1;
        end
        if (double_ev) begin
            tx_en_d = ~tx_en_q;
        end
    end

    // Any event restarts the blink train, sized from the mode being entered.
    always_comb begin
        blk_d    = blk_q;
        phase_d  = phase_q;
        blinks_d = blinks_q;
        if (single_ev || double_ev) begin
            blk_d    = BLK_ON;
            phase_d  = '0;
            blinks_d = {1'b0, mode_d} + 5'd1;
        end else begin
            case (blk_q)
                BLK_ON: begin
                    if (phase_q == BLINK_LAST) begin
                        blk_d    = BLK_GAP;
                        phase_d  = '0;
                        blinks_d = blinks_q - 5'd1;
                    end else begin
                        phase_d = phase_q + 24'd1;
                    end
                end
                BLK_GAP: begin
                    if (phase_q == BLINK_LAST) begin
                        blk_d   = (blinks_q != 5'd0) ? BLK_ON : BLK_OFF;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + 24'd1;
                    end
                end
                default: begin
                    blk_d   = BLK_OFF;
                    phase_d = '0;
                end
            endcase
        end
        led_d = (blk_d == BLK_ON);
    end

    assign bus.mode_o          = mode_q;
    assign bus.tx_en_o         = tx_en_q;
    assign bus.mode_chg_o      = mode_chg_q;
    assign bus.tx_chg_o        = tx_chg_q;
    assign bus.led_o           = led_q;
    assign bus.dbg_cls_state_o = cls_q;
    assign bus.dbg_blk_state_o = blk_q;
endmodule

// File: tb/tb_key_mode_ctrl.sv
// Directed bench for key_mode_ctrl with WIN_CYC=20, BLINK_CYC=5, NUM_MODES=4.
module tb_key_mode_ctrl;
    localparam int WIN   = 20;
    localparam int BLINK = 5;
    localparam int NM    = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;

    key_mode_ctrl_if bus();

    key_mode_ctrl #(.WIN_CYC(WIN), .BLINK_CYC(BLINK), .NUM_MODES(NM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Outputs packed as {mode[3:0], tx_en, mode_chg, tx_chg, led}.
    function automatic logic [7:0] pack_obs();
        return {bus.mode_o, bus.tx_en_o, bus.mode_chg_o, bus.tx_chg_o, bus.led_o};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Leaves the bench just after an edge, in cycle 0 of the test.
    task automatic do_reset();
        rst_n = 1'b0;
        bus.key_pulse_i = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.key_pulse_i = 1'b1;
        tick(); tick(); tick();
        rst_n = 1'b1;
        bus.key_pulse_i = 1'b0;
        for (int c = 0; c < 30; c++) begin
            n_vec++;
            if (pack_obs() !== 8'h00 || bus.dbg_cls_state_o !== 1'b0 || bus.dbg_blk_state_o !== 2'd0) begin
                n_err++;
                $display("FAIL reset c=%0d got out=%h cls=%b blk=%0d exp out=00 cls=0 blk=0",
                         c, pack_obs(), bus.dbg_cls_state_o, bus.dbg_blk_state_o);
            end
            tick();
        end
    endtask

    task automatic test_single();
        logic [7:0] exp;
        do_reset();
        for (int c = 0; c <= 60; c++) begin
            bus.key_pulse_i = (c == 10);
            exp = {(c >= 31) ? 4'd1 : 4'd0, 1'b0, (c == 31), 1'b0,
                   ((c >= 31 && c <= 35) || (c >= 41 && c <= 45))};
            n_vec++;
            if (pack_obs() !== exp) begin
                n_err++;
                $display("FAIL single c=%0d got=%h exp=%h", c, pack_obs(), exp);
            end
            tick();
        end
        bus.key_pulse_i = 1'b0;
    endtask

    task automatic test_mode_wrap();
        logic [6:0] exp;
        logic [3:0] m;
        do_reset();
        for (int c = 0; c <= 170; c++) begin
            bus.key_pulse_i = (c == 10 || c == 50 || c == 90 || c == 130);
            m = (c >= 151) ? 4'd0 : (c >= 111) ? 4'd3 : (c >= 71) ? 4'd2 : (c >= 31) ? 4'd1 : 4'd0;
            exp = {m, 1'b0, (c == 31 || c == 71 || c == 111 || c == 151), 1'b0};
            n_vec++;
            if (pack_obs() >> 1 !== {1'b0, exp}) begin
                n_err++;
                $display("FAIL mode_wrap c=%0d got=%h exp=%h", c, pack_obs() >> 1, exp);
            end
            tick();
        end
        bus.key_pulse_i = 1'b0;
    endtask

    task automatic test_double();
        logic [7:0] exp;
        do_reset();
        for (int c = 0; c <= 50; c++) begin
            bus.key_pulse_i = (c == 10 || c == 15);
            exp = {4'd0, (c >= 16), 1'b0, (c == 16), (c >= 16 && c <= 20)};
            n_vec++;
            if (pack_obs() !== exp) begin
                n_err++;
                $display("FAIL double c=%0d got=%h exp=%h", c, pack_obs(), exp);
            end
            if (bus.mode_chg_o && bus.tx_chg_o) begin
                n_err++;
                $display("FAIL both_chg c=%0d got=11 exp=not both", c);
            end
            tick();
        end
        bus.key_pulse_i = 1'b0;
    endtask

    task automatic test_window_edge();
        logic [6:0] exp;
        logic [3:0] m;
        do_reset();
        for (int c = 0; c <= 60; c++) begin
            bus.key_pulse_i = (c == 10 || c == 30);
            exp = {4'd0, (c >= 31), 1'b0, (c == 31)};
            n_vec++;
            if (pack_obs() >> 1 !== {1'b0, exp}) begin
                n_err++;
                $display("FAIL edge_double c=%0d got=%h exp=%h", c, pack_obs() >> 1, exp);
            end
            tick();
        end
        do_reset();
        for (int c = 0; c <= 70; c++) begin
            bus.key_pulse_i = (c == 10 || c == 31);
            m = (c >= 52) ? 4'd2 : (c >= 31) ? 4'd1 : 4'd0;
            exp = {m, 1'b0, (c == 31 || c == 52), 1'b0};
            n_vec++;
            if (pack_obs() >> 1 !== {1'b0, exp}) begin
                n_err++;
                $display("FAIL edge_single c=%0d got=%h exp=%h", c, pack_obs() >> 1, exp);
            end
            tick();
        end
        bus.key_pulse_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp;
        do_reset();
        for (int c = 0; c <= 60; c++) begin
            bus.key_pulse_i = (c == 10);
            rst_n = (c != 20);
            n_vec++;
            if (pack_obs() !== 8'h00) begin
                n_err++;
                $display("FAIL reset_window c=%0d got=%h exp=00", c, pack_obs());
            end
            tick();
        end
        do_reset();
        for (int c = 0; c <= 70; c++) begin
            bus.key_pulse_i = (c == 10);
            rst_n = (c != 33);
            exp = (c >= 31 && c <= 33) ? {4'd1, 1'b0, (c == 31), 1'b0, 1'b1} : 8'h00;
            n_vec++;
            if (pack_obs() !== exp) begin
                n_err++;
                $display("FAIL reset_blink c=%0d got=%h exp=%h", c, pack_obs(), exp);
            end
            tick();
        end
        rst_n = 1'b1;
        bus.key_pulse_i = 1'b0;
    endtask

    task automatic test_blink_restart();
        logic [7:0] exp;
        logic [3:0] m;
        logic       l;
        do_reset();
        for (int c = 0; c <= 180; c++) begin
            bus.key_pulse_i = (c == 10 || c == 50 || c == 90 || c == 122 || c == 124);
            m = (c >= 111) ? 4'd3 : (c >= 71) ? 4'd2 : (c >= 31) ? 4'd1 : 4'd0;
            l = (c >= 111 && c <= 115) || (c >= 121 && c <= 129) || (c >= 135 && c <= 139) ||
                (c >= 145 && c <= 149) || (c >= 155 && c <= 159);
            exp = {m, (c >= 125), (c == 111), (c == 125), l};
            if (c >= 100) begin
                n_vec++;
                if (pack_obs() !== exp) begin
                    n_err++;
                    $display("FAIL blink_restart c=%0d got=%h exp=%h", c, pack_obs(), exp);
                end
            end
            tick();
        end
        bus.key_pulse_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.key_pulse_i = 1'b0;
        test_reset();
        test_single();
        test_mode_wrap();
        test_double();
        test_window_edge();
        test_reset_mid();
        test_blink_restart();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/key_mode_ctrl.md
KEY_MODE_CTRL -- requirements
Module: key_mode_ctrl

Interface
REQ-001 Parameter WIN_CYC, default 6000000, length in clk cycles of the double-press window (300 ms at 20 MHz); legal range 2..2^24-1.
REQ-002 Parameter BLINK_CYC, default 4000000, length in clk cycles of each LED on and each LED off phase (200 ms at 20 MHz); legal range 1..2^24-1.
REQ-003 Parameter NUM_MODES, default 4, number of selectable modes; legal range 2..16.
REQ-004 clk  input  1  system clock, 20 MHz.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 key_pulse_i  input  1  one-cycle debounced key-press pulse from the key debouncer.
REQ-007 mode_o  output  4  current mode index, 0..NUM_MODES-1.
REQ-008 tx_en_o  output  1  backscatter transmit enable level.
REQ-009 mode_chg_o  output  1  one-cycle pulse when mode_o changes.
REQ-010 tx_chg_o  output  1  one-cycle pulse when tx_en_o toggles.
REQ-011 led_o  output  1  status LED, active-high.

Function
REQ-012 The press classifier SHALL be an FSM with two states: IDLE and WAIT2.
REQ-013 IDLE: key_pulse_i=1 -> WAIT2 with window counter cleared to 0; otherwise the FSM stays in IDLE.
REQ-014 WAIT2: key_pulse_i=1 -> double event, go to IDLE, clear counter.
REQ-015 WAIT2: key_pulse_i=0 with counter==WIN_CYC-1 -> single event, go to IDLE, clear counter.
REQ-016 WAIT2: otherwise the counter increments by 1 (24-bit counter; it never wraps because of REQ-015).
REQ-017 A pulse in the same cycle as counter==WIN_CYC-1 SHALL be classified as a double event, never as a single event.
REQ-018 A single event SHALL set mode_o to mode_o+1, wrapping from NUM_MODES-1 to 0, and SHALL assert mode_chg_o for exactly one cycle; both outputs update on the same edge that returns the FSM to IDLE.
REQ-019 Therefore mode_o SHALL change exactly WIN_CYC+1 cycles after the cycle in which the isolated key_pulse_i is high.
REQ-020 A double event SHALL invert tx_en_o and assert tx_chg_o for one cycle on the edge following the second pulse; mode_o is unchanged.
REQ-021 A third pulse arriving after a double event SHALL start a new classification from IDLE.
REQ-022 mode_chg_o and tx_chg_o SHALL never both be high in the same cycle.
REQ-023 The LED blinker SHALL be an FSM with states OFF, ON and GAP, a 24-bit phase counter and a 5-bit blink counter.
REQ-024 Any event (single or double) SHALL load blinks-remaining = new mode_o+1 and enter ON with the phase counter at 0.
REQ-025 A new event SHALL restart the sequence from ON even if a sequence is in progress.
REQ-026 ON: led_o=1; after BLINK_CYC cycles the FSM enters GAP and decrements blinks-remaining.
REQ-027 GAP: led_o=0; after BLINK_CYC cycles it enters ON if blinks-remaining>0, else OFF.
REQ-028 OFF: led_o=0, and led_o SHALL stay 0 until the next event.
REQ-029 All outputs SHALL be registered, with no combinational path from key_pulse_i to any output.

Reset
REQ-030 While rst_n=0 at a clk edge, the block SHALL set: classifier IDLE, blinker OFF, all counters 0, mode_o=0, tx_en_o=0, mode_chg_o=0, tx_chg_o=0, led_o=0.
REQ-031 Reset asserted in mid-window or mid-blink SHALL abandon the pending classification and the blink sequence, with no event emitted.
REQ-032 A key_pulse_i during a reset cycle SHALL be ignored.

Verification (bench uses WIN_CYC=20, BLINK_CYC=5, NUM_MODES=4)
REQ-033 Single pulse at cycle 10 -> mode_o 0->1 and mode_chg_o high at cycle 31 only; led_o high for 5 cycles, low for 5, high for 5, then low.
REQ-034 Four isolated pulses spaced 40 cycles -> mode_o 1,2,3,0 (wrap); tx_en_o stays 0.
REQ-035 Pulses at cycles 10 and 15 -> tx_en_o 0->1 with tx_chg_o at cycle 16; mode_o stays 0; no mode_chg_o.
REQ-036 Pulses at cycles 10 and 30 (counter==19 at the second pulse) -> double event, tx_en_o toggles; pulses at cycles 10 and 31 -> single event at 31, then the second pulse opens a new window.
REQ-037 Reset asserted at cycle 20 after a pulse at cycle 10 -> no event; all outputs 0 for the following 40 cycles.
REQ-038 Double event issued during an active blink with mode_o=3 -> blink sequence restarts with 4 blinks.
